// File: rtl/axi_lite_sub_regfile.sv
// axi_lite_sub_regfile
//   AXI-Lite subordinate that terminates the AW/W/B and AR/R channels and
//   backs them with a byte-strobed register file of NUM_REGS words.
//   The write and read paths are independent, and each allows one
//   outstanding transaction. Register contents are also exported flat.
// Ports
//   clk, ARESETn                   clock and synchronous active-low reset
//   AWVALID/AWREADY/AWADDR         write address channel
//   WVALID/WREADY/WDATA/WSTRB      write data channel
//   BVALID/BREADY/BRESP            write response channel
//   ARVALID/ARREADY/ARADDR         read address channel
//   RVALID/RREADY/RDATA/RRESP      read data channel
//   reg_out                        reg[i] at [i*DATA_WIDTH +: DATA_WIDTH]
module axi_lite_sub_regfile #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int NUM_REGS      = 16
) (
  input  logic                           clk,
  input  logic                           ARESETn,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [ADDRESS_WIDTH-1:0]       AWADDR,
  input  logic                           WVALID,
  output logic                           WREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [STRB_WIDTH-1:0]          WSTRB,
  output logic                           BVALID,
  input  logic                           BREADY,
  output logic [1:0]                     BRESP,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  input  logic [ADDRESS_WIDTH-1:0]       ARADDR,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int OFF_W = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 1;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_LIMIT = ADDRESS_WIDTH'(NUM_REGS * STRB_WIDTH);

  typedef enum logic [0:0] {WR_COLLECT = 1'b0, WR_RESP = 1'b1} wr_state_e;
  typedef enum logic [0:0] {RD_IDLE = 1'b0, RD_DATA = 1'b1} rd_state_e;

  function automatic logic addr_in_range(input logic [ADDRESS_WIDTH-1:0] addr);
    return (addr < ADDR_LIMIT);
  endfunction

  // Byte-offset bits below the word index are ignored.
  function automatic logic [IDX_W-1:0] reg_index(input logic [ADDRESS_WIDTH-1:0] addr);
    return addr[OFF_W +: IDX_W];
  endfunction

  wr_state_e                  wr_state_q, wr_state_d;
  rd_state_e                  rd_state_q, rd_state_d;
  logic                       aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDRESS_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]      wstrb_q, wstrb_d;
  logic                       awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic                       bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]                 bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]      regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]      regs_d [NUM_REGS];
  logic                       aw_hs_s, w_hs_s, ar_hs_s, b_hs_s, r_hs_s, commit_s;

  assign aw_hs_s = AWVALID && awready_q;
  assign w_hs_s  = WVALID && wready_q;
  assign ar_hs_s = ARVALID && arready_q;
  assign b_hs_s  = (wr_state_q == WR_RESP) && BREADY;
  assign r_hs_s  = (rd_state_q == RD_DATA) && RREADY;

  // Capture AW and W independently; both held flags clear on the B handshake.
  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    if (b_hs_s) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end else begin
      if (aw_hs_s) begin
        aw_held_d = 1'b1;
        awaddr_d  = AWADDR;
      end else begin
        aw_held_d = aw_held_q;
      end
      if (w_hs_s) begin
        w_held_d = 1'b1;
        wdata_d  = WDATA;
        wstrb_d  = WSTRB;
      end else begin
        w_held_d = w_held_q;
      end
    end
  end

  // Write FSM next state: commit on the edge where both halves become held.
  always_comb begin
    wr_state_d = wr_state_q;
    commit_s   = 1'b0;
    case (wr_state_q)
      WR_COLLECT: begin
        if (aw_held_d && w_held_d) begin
          commit_s   = 1'b1;
          wr_state_d = WR_RESP;
        end else begin
          wr_state_d = WR_COLLECT;
        end
      end
      WR_RESP: begin
        if (BREADY) wr_state_d = WR_COLLECT;
        else        wr_state_d = WR_RESP;
      end
      default: wr_state_d = WR_COLLECT;
    endcase
  end

  // Write-side outputs, registered: READYs follow the next state and held flags.
  always_comb begin
    awready_d = (wr_state_d == WR_COLLECT) && !aw_held_d;
    wready_d  = (wr_state_d == WR_COLLECT) && !w_held_d;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (commit_s) begin
      bvalid_d = 1'b1;
      bresp_d  = addr_in_range(awaddr_d) ? RESP_OKAY : RESP_SLVERR;
    end else if (b_hs_s) begin
      bvalid_d = 1'b0;
    end else begin
      bvalid_d = bvalid_q;
    end
  end

  // Register file update: strobed bytes of the addressed word on commit.
  always_comb begin
    regs_d = regs_q;
    if (commit_s && addr_in_range(awaddr_d)) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb_d[b]) regs_d[reg_index(awaddr_d)][8*b +: 8] = wdata_d[8*b +: 8];
        else            regs_d[reg_index(awaddr_d)][8*b +: 8] = regs_q[reg_index(awaddr_d)][8*b +: 8];
      end
    end else begin
      regs_d = regs_q;
    end
  end

  // Read FSM next state.
  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs_s) rd_state_d = RD_DATA;
        else         rd_state_d = RD_IDLE;
      end
      RD_DATA: begin
        if (RREADY) rd_state_d = RD_IDLE;
        else        rd_state_d = RD_DATA;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Read-side outputs: data sampled from regs_q, so a same-edge write is not seen.
  always_comb begin
    arready_d = (rd_state_d == RD_IDLE);
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (ar_hs_s) begin
      rvalid_d = 1'b1;
      if (addr_in_range(ARADDR)) begin
        rdata_d = regs_q[reg_index(ARADDR)];
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end
    end else if (r_hs_s) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!ARESETn) begin
      wr_state_q <= WR_COLLECT;
      rd_state_q <= RD_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      arready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      arready_q  <= arready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign ARREADY = arready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
    assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
  end

endmodule

// File: tb/tb_axi_lite_sub_regfile.sv
// tb_axi_lite_sub_regfile
//   Self-checking bench for axi_lite_sub_regfile (default parameters).
//   Expected responses are pushed to a scoreboard queue when a transaction
//   is issued and popped when the DUT responds; a word-array model tracks
//   register contents.
module tb_axi_lite_sub_regfile;
  localparam int NR = 16;
  localparam int DW = 32;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic              clk = 1'b0;
  logic              ARESETn = 1'b0;
  logic              AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b1, ARVALID = 1'b0, RREADY = 1'b1;
  logic [31:0]       AWADDR = 32'h0, ARADDR = 32'h0, WDATA = 32'h0;
  logic [3:0]        WSTRB = 4'h0;
  logic              AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]        BRESP, RRESP;
  logic [31:0]       RDATA;
  logic [NR*DW-1:0]  reg_out;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  logic [31:0] model [NR];
  int          checks = 0;
  int          errors = 0;

  axi_lite_sub_regfile dut (
    .clk(clk), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .reg_out(reg_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
    return f;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] addr);
    return (addr < 32'd64) ? OKAY : SLVERR;
  endfunction

  function automatic void model_write(input logic [31:0] addr, data, input logic [3:0] strb);
    if (addr < 32'd64) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[addr[5:2]][8*b +: 8] = data[8*b +: 8];
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    return (addr < 32'd64) ? model[addr[5:2]] : 32'h0;
  endfunction

  // Issue AW and W together, wait (bounded) for B, complete the handshake.
  task automatic axi_write(input logic [31:0] addr, data, input logic [3:0] strb,
                           output logic [1:0] resp, output bit to);
    bit aw_done, w_done, aw_now, w_now;
    to = 1'b0; resp = 2'b11; aw_done = 1'b0; w_done = 1'b0;
    AWADDR = addr; AWVALID = 1'b1; WDATA = data; WSTRB = strb; WVALID = 1'b1; BREADY = 1'b1;
    for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
      aw_now = AWVALID && AWREADY;
      w_now  = WVALID && WREADY;
      tick();
      if (aw_now) begin AWVALID = 1'b0; aw_done = 1'b1; end
      if (w_now)  begin WVALID  = 1'b0; w_done  = 1'b1; end
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    for (int n = 0; n < 20 && !BVALID; n++) tick();
    if (!BVALID) to = 1'b1;
    else begin resp = BRESP; tick(); end
  endtask

  // Issue AR, wait (bounded) for R, complete the handshake.
  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output bit to);
    bit ar_now;
    to = 1'b0; resp = 2'b11; data = 32'hX;
    ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
    for (int n = 0; n < 20; n++) begin
      ar_now = ARREADY;
      tick();
      if (ar_now) break;
    end
    ARVALID = 1'b0;
    for (int n = 0; n < 20 && !RVALID; n++) tick();
    if (!RVALID) to = 1'b1;
    else begin data = RDATA; resp = RRESP; tick(); end
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    tick(); tick();
    checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
    end
    checks++;
    if (reg_out !== '0) begin errors++; $display("FAIL reset_regs: got %h expected 0", reg_out); end
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    ARESETn = 1'b1;
    tick();
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      errors++; $display("FAIL reset_release_ready: got %b expected 111", {AWREADY, WREADY, ARREADY});
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] d; logic [1:0] r; bit to;
    AWADDR = 32'h08; AWVALID = 1'b1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b1;
    sb_q.push_back('{32'h0, exp_resp(32'h08)});
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    model_write(32'h08, 32'hDEADBEEF, 4'hF);
    e = sb_q.pop_front();
    checks++;
    if (BVALID !== 1'b1 || BRESP !== e.resp) begin
      errors++; $display("FAIL same_cycle_b: got valid=%b resp=%b expected 1/%b", BVALID, BRESP, e.resp);
    end
    tick();
    checks++;
    if (BVALID !== 1'b0 || AWREADY !== 1'b1 || WREADY !== 1'b1) begin
      errors++; $display("FAIL same_cycle_b_done: got b=%b aw=%b w=%b expected 0 1 1", BVALID, AWREADY, WREADY);
    end
    checks++;
    if (reg_out[2*DW +: DW] !== model[2]) begin
      errors++; $display("FAIL same_cycle_reg2: got %h expected %h", reg_out[2*DW +: DW], model[2]);
    end
    sb_q.push_back('{model_read(32'h08), exp_resp(32'h08)});
    axi_read(32'h08, d, r, to);
    e = sb_q.pop_front();
    checks++;
    if (to || d !== e.data || r !== e.resp) begin
      errors++; $display("FAIL same_cycle_read: got to=%0d data=%h resp=%b expected %h/%b", to, d, r, e.data, e.resp);
    end
  endtask

  task automatic test_w_first();
    WDATA = 32'h11223344; WSTRB = 4'b0101; WVALID = 1'b1; BREADY = 1'b1;
    tick();
    WVALID = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (WREADY !== 1'b0 || BVALID !== 1'b0 || AWREADY !== 1'b1) begin
        errors++; $display("FAIL w_first_wait: got w=%b b=%b aw=%b expected 0 0 1", WREADY, BVALID, AWREADY);
      end
      tick();
    end
    AWADDR = 32'h08; AWVALID = 1'b1;
    sb_q.push_back('{32'h0, exp_resp(32'h08)});
    tick();
    AWVALID = 1'b0;
    model_write(32'h08, 32'h11223344, 4'b0101);
    e = sb_q.pop_front();
    checks++;
    if (BVALID !== 1'b1 || BRESP !== e.resp) begin
      errors++; $display("FAIL w_first_b: got valid=%b resp=%b expected 1/%b", BVALID, BRESP, e.resp);
    end
    tick();
    checks++;
    if (reg_out[2*DW +: DW] !== model[2]) begin
      errors++; $display("FAIL w_first_merge: got %h expected %h", reg_out[2*DW +: DW], model[2]);
    end
  endtask

  task automatic test_backpressure();
    BREADY = 1'b0;
    AWADDR = 32'h0C; AWVALID = 1'b1; WDATA = 32'hA5A50F0F; WSTRB = 4'hF; WVALID = 1'b1;
    sb_q.push_back('{32'h0, exp_resp(32'h0C)});
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    model_write(32'h0C, 32'hA5A50F0F, 4'hF);
    e = sb_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (BVALID !== 1'b1 || BRESP !== e.resp || AWREADY !== 1'b0 || WREADY !== 1'b0) begin
        errors++; $display("FAIL bp_b_hold: got b=%b resp=%b aw=%b w=%b expected 1 %b 0 0", BVALID, BRESP, AWREADY, WREADY, e.resp);
      end
      tick();
    end
    BREADY = 1'b1;
    tick();
    checks++;
    if (BVALID !== 1'b0 || AWREADY !== 1'b1) begin
      errors++; $display("FAIL bp_b_release: got b=%b aw=%b expected 0 1", BVALID, AWREADY);
    end
    RREADY = 1'b0;
    ARADDR = 32'h0C; ARVALID = 1'b1;
    sb_q.push_back('{model_read(32'h0C), exp_resp(32'h0C)});
    tick();
    ARVALID = 1'b0;
    e = sb_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (RVALID !== 1'b1 || RDATA !== e.data || RRESP !== e.resp || ARREADY !== 1'b0) begin
        errors++; $display("FAIL bp_r_hold: got r=%b data=%h resp=%b ar=%b expected 1 %h %b 0", RVALID, RDATA, RRESP, ARREADY, e.data, e.resp);
      end
      tick();
    end
    RREADY = 1'b1;
    tick();
    checks++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
      errors++; $display("FAIL bp_r_release: got r=%b ar=%b expected 0 1", RVALID, ARREADY);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r; bit to;
    sb_q.push_back('{32'h0, exp_resp(32'h40)});
    axi_write(32'h40, 32'hFFFFFFFF, 4'hF, r, to);
    model_write(32'h40, 32'hFFFFFFFF, 4'hF);
    e = sb_q.pop_front();
    checks++;
    if (to || r !== e.resp) begin
      errors++; $display("FAIL oor_write_resp: got to=%0d resp=%b expected %b", to, r, e.resp);
    end
    checks++;
    if (reg_out !== model_flat()) begin
      errors++; $display("FAIL oor_regs_unchanged: got %h expected %h", reg_out, model_flat());
    end
    sb_q.push_back('{model_read(32'h40), exp_resp(32'h40)});
    axi_read(32'h40, d, r, to);
    e = sb_q.pop_front();
    checks++;
    if (to || d !== e.data || r !== e.resp) begin
      errors++; $display("FAIL oor_read: got to=%0d data=%h resp=%b expected %h/%b", to, d, r, e.data, e.resp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, wd, d; logic [3:0] s; logic [1:0] r; bit to;
    for (int i = 0; i < 10; i++) begin
      a  = 32'($urandom_range(0, 17)) * 32'd4 + 32'($urandom_range(0, 3));
      wd = $urandom;
      s  = 4'($urandom_range(0, 15));
      sb_q.push_back('{32'h0, exp_resp(a)});
      axi_write(a, wd, s, r, to);
      model_write(a, wd, s);
      e = sb_q.pop_front();
      checks++;
      if (to || r !== e.resp) begin
        errors++; $display("FAIL b2b_write[%0d]: addr=%h got to=%0d resp=%b expected %b", i, a, to, r, e.resp);
      end
      sb_q.push_back('{model_read(a), exp_resp(a)});
      axi_read(a, d, r, to);
      e = sb_q.pop_front();
      checks++;
      if (to || d !== e.data || r !== e.resp) begin
        errors++; $display("FAIL b2b_read[%0d]: addr=%h got to=%0d data=%h resp=%b expected %h/%b", i, a, to, d, r, e.data, e.resp);
      end
    end
    checks++;
    if (reg_out !== model_flat()) begin
      errors++; $display("FAIL b2b_reg_out: got %h expected %h", reg_out, model_flat());
    end
  endtask

  task automatic test_collision_and_reset();
    logic [31:0] d; logic [1:0] r; bit to;
    axi_write(32'h14, 32'h01010101, 4'hF, r, to);
    model_write(32'h14, 32'h01010101, 4'hF);
    AWADDR = 32'h14; AWVALID = 1'b1; WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WVALID = 1'b1;
    ARADDR = 32'h14; ARVALID = 1'b1; BREADY = 1'b1; RREADY = 1'b1;
    sb_q.push_back('{model_read(32'h14), OKAY});
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    model_write(32'h14, 32'hCAFEF00D, 4'hF);
    e = sb_q.pop_front();
    checks++;
    if (RVALID !== 1'b1 || RDATA !== e.data || BVALID !== 1'b1) begin
      errors++; $display("FAIL collision_old_value: got r=%b data=%h b=%b expected 1 %h 1", RVALID, RDATA, BVALID, e.data);
    end
    tick();
    sb_q.push_back('{model_read(32'h14), OKAY});
    axi_read(32'h14, d, r, to);
    e = sb_q.pop_front();
    checks++;
    if (to || d !== e.data || r !== e.resp) begin
      errors++; $display("FAIL collision_new_value: got to=%0d data=%h resp=%b expected %h/%b", to, d, r, e.data, e.resp);
    end
    AWADDR = 32'h00; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    checks++;
    if (AWREADY !== 1'b0 || WREADY !== 1'b1) begin
      errors++; $display("FAIL midwrite_aw_held: got aw=%b w=%b expected 0 1", AWREADY, WREADY);
    end
    ARESETn = 1'b0;
    tick();
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    checks++;
    if (BVALID !== 1'b0 || reg_out !== model_flat()) begin
      errors++; $display("FAIL midwrite_reset: got b=%b regs=%h expected 0 and all zero", BVALID, reg_out);
    end
    ARESETn = 1'b1;
    WDATA = 32'hFFFFFFFF; WSTRB = 4'hF; WVALID = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (BVALID !== 1'b0) begin
        errors++; $display("FAIL midwrite_no_b[%0d]: got b=%b expected 0", c, BVALID);
      end
    end
    WVALID = 1'b0;
    checks++;
    if (reg_out !== model_flat()) begin
      errors++; $display("FAIL midwrite_regs_clear: got %h expected %h", reg_out, model_flat());
    end
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_w_first();
    test_backpressure();
    test_out_of_range();
    test_back_to_back();
    test_collision_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
